// File: rtl/f_fetch_fd.sv
// -----------------------------------------------------------------------------
// f_fetch_fd
//
// Fetch stage plus F/D pipeline register of the five-stage MIPS pipeline.
//
// This block holds the architectural fetch PC and presents it to the external
// instruction memory. On every unstalled cycle it loads the next PC computed by
// the D-stage next-PC logic. The fetched word, its PC and an address-error flag
// are captured into the F/D register.
//
// An address error does not redirect the pipeline. The error is carried
// downstream as D_adel, together with a nop payload.
//
// Ports:
//   clk           pipeline clock; all state changes on the rising edge
//   reset         synchronous, active-high reset
//   stall         hazard-unit stall; freezes the PC and the F/D register
//   npc           next PC from the D-stage next-PC logic
//   i_inst_rdata  instruction word at i_inst_addr (combinational read)
//   i_inst_addr   instruction memory address (always equal to F_pc)
//   F_pc          current fetch PC
//   F_adel        fetch address error for F_pc (combinational)
//   D_pc          PC of the instruction held in F/D
//   D_instr       instruction held in F/D (nop when D_adel is set)
//   D_valid       F/D holds a fetched instruction, not a reset bubble
//   D_adel        address-error flag accompanying D_instr
// -----------------------------------------------------------------------------
module f_fetch_fd #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_TOP   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_pc,
    output logic        F_adel,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_adel
);

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [31:0] pc_q,      pc_d;
    logic [31:0] d_pc_q,    d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic        d_adel_q,  d_adel_d;
    logic        f_adel;

    // Misaligned addresses, and addresses outside the instruction window, raise
    // an address error. The compares are unsigned, so a PC that wraps to 0
    // lands below IM_BASE and is flagged.
    assign f_adel = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_TOP);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no path
        // through the block leaves a signal unassigned and infers a latch.
        pc_d      = pc_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_valid_d = d_valid_q;
        d_adel_d  = d_adel_q;

        // A stall keeps the defaults, so the PC and all F/D fields hold.
        // An illegal npc is loaded unchanged; no clamping is applied.
        if (!stall) begin
            pc_d      = npc;
            d_pc_d    = pc_q;
            d_instr_d = f_adel ? NOP : i_inst_rdata;
            d_valid_d = 1'b1;
            d_adel_d  = f_adel;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the values from before the edge. Reset is synchronous and
        // takes priority over stall.
        if (reset) begin
            pc_q      <= RESET_PC;
            d_pc_q    <= 32'h0;
            d_instr_q <= NOP;
            d_valid_q <= 1'b0;
            d_adel_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_valid_q <= d_valid_d;
            d_adel_q  <= d_adel_d;
        end
    end

    assign i_inst_addr = pc_q;
    assign F_pc        = pc_q;
    assign F_adel      = f_adel;
    assign D_pc        = d_pc_q;
    assign D_instr     = d_instr_q;
    assign D_valid     = d_valid_q;
    assign D_adel      = d_adel_q;

endmodule

// File: tb/tb_f_fetch_fd.sv
module tb_f_fetch_fd;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] npc;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] F_pc;
    logic        F_adel;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_adel;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_dpc;
    logic [31:0] m_dinstr;
    logic        m_dvalid;
    logic        m_dadel;

    f_fetch_fd #(
        .RESET_PC(RESET_PC),
        .IM_BASE (IM_BASE),
        .IM_TOP  (IM_TOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc         (npc),
        .i_inst_rdata(i_inst_rdata),
        .i_inst_addr (i_inst_addr),
        .F_pc        (F_pc),
        .F_adel      (F_adel),
        .D_pc        (D_pc),
        .D_instr     (D_instr),
        .D_valid     (D_valid),
        .D_adel      (D_adel)
    );

    always #5 clk = ~clk;

    // The instruction memory returns a word tagged with its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= IM_BASE) && (a <= IM_TOP);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("i_inst_addr", i_inst_addr,    m_pc);
        check("F_pc",        F_pc,           m_pc);
        check("F_adel",      32'(F_adel),    32'(!legal(m_pc)));
        check("D_pc",        D_pc,           m_dpc);
        check("D_instr",     D_instr,        m_dinstr);
        check("D_valid",     32'(D_valid),   32'(m_dvalid));
        check("D_adel",      32'(D_adel),    32'(m_dadel));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check the
    // DUT 1 ns after the edge.
    task automatic step(input logic r, input logic s, input logic [31:0] n);
        reset = r;
        stall = s;
        npc   = n;
        @(posedge clk);
        if (r) begin
            m_pc     = RESET_PC;
            m_dpc    = 32'h0;
            m_dinstr = 32'h0;
            m_dvalid = 1'b0;
            m_dadel  = 1'b0;
        end else if (!s) begin
            m_dpc    = m_pc;
            m_dadel  = !legal(m_pc);
            m_dinstr = legal(m_pc) ? mem_word(m_pc) : 32'h0;
            m_dvalid = 1'b1;
            m_pc     = n;
        end
        #1;
        check_all();
    endtask

    initial begin
        m_pc     = 32'hx;
        m_dpc    = 32'hx;
        m_dinstr = 32'hx;
        m_dvalid = 1'bx;
        m_dadel  = 1'bx;

        // Reset alone, then reset together with stall.
        step(1, 0, 32'h1234_5678);
        step(1, 0, 32'h1234_5678);
        step(1, 1, 32'hDEAD_BEEF);

        // Sequential fetch from 0x3000 up to 0x3008.
        step(0, 0, 32'h3004);
        step(0, 0, 32'h3008);

        // Stall for 3 cycles at F_pc=0x3008 while npc toggles.
        step(0, 1, 32'h4000);
        step(0, 1, 32'h5000);
        step(0, 1, 32'h2000);
        check("stall_hold_pc",  F_pc, 32'h3008);
        check("stall_hold_dpc", D_pc, 32'h3004);

        // Release the stall, then take a branch redirect from 0x3010.
        step(0, 0, 32'h300C);
        step(0, 0, 32'h3010);
        step(0, 0, 32'h3100);
        check("redirect_fpc", F_pc, 32'h3100);
        check("delay_slot",   D_pc, 32'h3010);
        step(0, 0, 32'h3102);
        check("redirect_dpc", D_pc, 32'h3100);

        // Misaligned fetch at 0x3102.
        step(0, 0, 32'h7000);
        check("misalign_adel", 32'(D_adel), 32'd1);
        check("misalign_nop",  D_instr, 32'h0);

        // Out-of-range fetches, then the top legal address.
        step(0, 0, 32'h2FFC);
        step(0, 0, 32'h6FFC);
        step(0, 0, 32'hFFFF_FFFC);
        check("top_ok", 32'(D_adel), 32'd0);
        step(0, 0, 32'h0);
        step(0, 0, 32'h3000);

        // Reset asserted in the middle of a stall.
        step(0, 1, 32'h3333_3330);
        step(1, 1, 32'h3333_3330);
        step(0, 0, 32'h3004);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        s;
            logic [31:0] n;
            int          k;
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 25);
            k = $urandom_range(0, 9);
            if (k < 5)
                n = m_pc + 32'd4;
            else if (k < 7)
                n = IM_BASE + {$urandom_range(0, 32'h0FFF), 2'b00};
            else if (k < 8)
                n = $urandom;
            else if (k < 9)
                n = {$urandom_range(0, 1) ? IM_TOP[31:2] : IM_BASE[31:2], 2'b00}
                    + ($urandom_range(0, 1) ? 32'd4 : -32'd4);
            else
                n = 32'hFFFF_FFFC;
            step(r, s, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/f_fetch_fd.md
# f_fetch_fd

Fetch stage plus F/D pipeline register for the five-stage MIPS pipeline. Holds the architectural fetch PC, presents it to the external instruction memory, and loads the next-PC produced by the D-stage next-PC logic every non-stalled cycle. Captures the fetched instruction, its PC and an address-error flag into the F/D register consumed by decode, the D-stage next-PC logic and the hazard unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address (inclusive).
- IM_TOP, 32'h0000_6FFC, highest legal instruction address (inclusive).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; 1 freezes PC and F/D register.
- npc  input  32  next PC from D-stage next-PC logic.
- i_inst_rdata  input  32  instruction word at i_inst_addr (combinational read).
- i_inst_addr  output  32  instruction memory address; equals F_pc.
- F_pc  output  32  current fetch PC; fed back to next-PC logic for PC+4.
- F_adel  output  1  fetch address error for F_pc (combinational).
- D_pc  output  32  PC of instruction held in F/D.
- D_instr  output  32  instruction held in F/D.
- D_valid  output  1  F/D holds a fetched (not reset-bubble) instruction.
- D_adel  output  1  address-error flag accompanying D_instr.

## Operation
- PC register: reset -> RESET_PC; else if stall==0 -> npc; else hold.
- F_adel = (F_pc[1:0] != 0) | (F_pc < IM_BASE) | (F_pc > IM_TOP); unsigned 32-bit compares.
- i_inst_addr = F_pc always, including when F_adel=1 (memory result ignored then).
- F/D register on reset: D_pc=0, D_instr=0, D_valid=0, D_adel=0.
- F/D register when stall==0: D_pc<=F_pc; D_instr<= F_adel ? 32'h0 (nop) : i_inst_rdata; D_adel<=F_adel; D_valid<=1.
- F/D register when stall==1: all four fields hold.
- Illegal npc is still loaded into PC (no clamping); the error travels with the instruction as D_adel with a nop payload; exception handling is downstream.
- No flush input: branch delay slot always executes, so the instruction after a branch is never squashed.
- npc is sampled only when stall==0; npc value during stalled cycles is don't-care.

## Timing
- Combinational: F_pc -> i_inst_addr, F_adel; i_inst_rdata -> D_instr next-state. No combinational path from npc or stall to any output.
- Latency: instruction at PC X appears on D_instr/D_pc one edge after F_pc==X with stall==0.
- First cycle after reset: F_pc=RESET_PC, D_valid=0; after first unstalled edge D_pc=RESET_PC, D_valid=1.
- Redirect: npc target applied at the edge it is presented; following cycle F_pc=target, D holds the delay-slot instruction.
- Stall for N cycles: F_pc, D_pc, D_instr, D_adel, D_valid all constant for N edges; resume with the npc present on the first unstalled edge.
- reset and stall both 1: reset wins; all state to reset values.
- Reset asserted mid-stall: same as above; stall ignored until reset deasserts.
- PC wrap at 32'hFFFF_FFFC -> npc 0: loaded unchanged, F_adel=1 (below IM_BASE).

## Test plan
- Reset: hold reset 2 cycles -> F_pc=0x3000, D_pc=0, D_instr=0, D_valid=0, D_adel=0; with reset and stall both 1 same result.
- Sequential fetch: npc=F_pc+4, memory returns addr-tagged words -> D_pc steps 0x3000,0x3004,0x3008 one cycle behind F_pc, D_instr matches word at D_pc, D_valid=1.
- Stall: assert stall 3 cycles at F_pc=0x3008 with npc toggling -> F_pc stays 0x3008, D_pc stays 0x3004, D_instr unchanged; release -> F_pc=npc next edge.
- Branch redirect: at F_pc=0x3010 drive npc=0x3100 -> next cycle F_pc=0x3100, D_pc=0x3010 (delay slot); following cycle D_pc=0x3100.
- Misaligned npc=0x3102 -> F_adel=1; next edge D_adel=1, D_instr=0, D_pc=0x3102.
- Out of range: npc=0x7000 and npc=0x2FFC -> F_adel=1, D_instr=0; npc=0x6FFC -> F_adel=0, normal fetch.
